dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the UART
// loader/dumper (io side) and the CPU core (core side). Each side's request
// is captured on its rising edge into a one-deep slot. Pending slots are
// granted round-robin and the memory strobe is held until mem_ready or the
// watchdog fires.
module dmem_arbiter #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] io_addr,
    input  logic [31:0] io_wdata,
    input  logic        io_read,
    input  logic        io_write,
    output logic [31:0] io_rdata,
    output logic        io_ready,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    input  logic        c_read,
    input  logic        c_write,
    output logic [31:0] c_rdata,
    output logic        c_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        drop_err,
    output logic        timeout_err
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    localparam logic SIDE_IO   = 1'b0;
    localparam logic SIDE_CORE = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    logic             io_req_q_r;
    logic             c_req_q_r;
    logic             io_pend_r;
    logic             c_pend_r;
    logic [31:0]      io_slot_addr_r;
    logic [31:0]      io_slot_wdata_r;
    logic             io_slot_wr_r;
    logic [31:0]      c_slot_addr_r;
    logic [31:0]      c_slot_wdata_r;
    logic             c_slot_wr_r;
    state_t           state_r;
    logic             last_grant_r;
    logic             grant_r;
    logic [CNT_W-1:0] wait_cnt_r;

    logic io_cap_s;
    logic c_cap_s;
    logic io_acc_s;
    logic c_acc_s;
    logic io_drop_s;
    logic c_drop_s;
    logic pick_io_s;
    logic wd_hit_s;

    // Request edge detection: accept into an empty slot, flag lost or ambiguous requests.
    always_comb begin
        io_cap_s  = (io_read | io_write) & ~io_req_q_r;
        c_cap_s   = (c_read | c_write) & ~c_req_q_r;
        io_acc_s  = io_cap_s & ~io_pend_r;
        c_acc_s   = c_cap_s & ~c_pend_r;
        io_drop_s = io_cap_s & (io_pend_r | (io_read & io_write));
        c_drop_s  = c_cap_s & (c_pend_r | (c_read & c_write));
    end

    // Round-robin choice: on a tie the side not served last wins.
    always_comb begin
        pick_io_s = 1'b0;
        if (io_pend_r && c_pend_r) begin
            pick_io_s = (last_grant_r == SIDE_CORE);
        end else if (io_pend_r) begin
            pick_io_s = 1'b1;
        end else begin
            pick_io_s = 1'b0;
        end
    end

    // Watchdog expiry; a zero TIMEOUT disables it entirely.
    always_comb begin
        wd_hit_s = 1'b0;
        if (TIMEOUT != 0) begin
            wd_hit_s = (wait_cnt_r == CNT_LAST);
        end else begin
            wd_hit_s = 1'b0;
        end
    end

    // Request history and slot capture; a write wins when read and write arrive together.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            io_req_q_r      <= 1'b0;
            c_req_q_r       <= 1'b0;
            io_slot_addr_r  <= 32'h0;
            io_slot_wdata_r <= 32'h0;
            io_slot_wr_r    <= 1'b0;
            c_slot_addr_r   <= 32'h0;
            c_slot_wdata_r  <= 32'h0;
            c_slot_wr_r     <= 1'b0;
        end else begin
            io_req_q_r <= io_read | io_write;
            c_req_q_r  <= c_read | c_write;
            if (io_acc_s) begin
                io_slot_addr_r  <= io_addr;
                io_slot_wdata_r <= io_wdata;
                io_slot_wr_r    <= io_write;
            end
            if (c_acc_s) begin
                c_slot_addr_r  <= c_addr;
                c_slot_wdata_r <= c_wdata;
                c_slot_wr_r    <= c_write;
            end
        end
    end

    // Grant FSM: drives the memory port and returns data/ready to the winner.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r      <= ST_IDLE;
            last_grant_r <= SIDE_CORE;
            grant_r      <= SIDE_IO;
            wait_cnt_r   <= '0;
            io_pend_r    <= 1'b0;
            c_pend_r     <= 1'b0;
            mem_addr     <= 32'h0;
            mem_wdata    <= 32'h0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            io_rdata     <= 32'h0;
            c_rdata      <= 32'h0;
            io_ready     <= 1'b0;
            c_ready      <= 1'b0;
            drop_err     <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            io_ready <= 1'b0;
            c_ready  <= 1'b0;
            if (io_acc_s) begin
                io_pend_r <= 1'b1;
            end
            if (c_acc_s) begin
                c_pend_r <= 1'b1;
            end
            if (io_drop_s || c_drop_s) begin
                drop_err <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (io_pend_r || c_pend_r) begin
                        grant_r    <= pick_io_s ? SIDE_IO : SIDE_CORE;
                        mem_addr   <= pick_io_s ? io_slot_addr_r : c_slot_addr_r;
                        mem_wdata  <= pick_io_s ? io_slot_wdata_r : c_slot_wdata_r;
                        mem_write  <= pick_io_s ? io_slot_wr_r : c_slot_wr_r;
                        mem_read   <= pick_io_s ? ~io_slot_wr_r : ~c_slot_wr_r;
                        wait_cnt_r <= '0;
                        state_r    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (mem_ready || wd_hit_s) begin
                        // Completion and watchdog abort share the hand-back path;
                        // an aborted access returns zero data.
                        mem_read     <= 1'b0;
                        mem_write    <= 1'b0;
                        last_grant_r <= grant_r;
                        state_r      <= ST_IDLE;
                        if (!mem_ready) begin
                            timeout_err <= 1'b1;
                        end
                        if (grant_r == SIDE_IO) begin
                            io_ready  <= 1'b1;
                            io_pend_r <= 1'b0;
                            if (!mem_ready) begin
                                io_rdata <= 32'h0;
                            end else if (mem_read) begin
                                io_rdata <= mem_rdata;
                            end
                        end else begin
                            c_ready  <= 1'b1;
                            c_pend_r <= 1'b0;
                            if (!mem_ready) begin
                                c_rdata <= 32'h0;
                            end else if (mem_read) begin
                                c_rdata <= mem_rdata;
                            end
                        end
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a memory model acks after a chosen
// delay, a monitor pops expected accesses and ready pulses from scoreboards.
module tb_dmem_arbiter;

    localparam logic SIDE_IO   = 1'b0;
    localparam logic SIDE_CORE = 1'b1;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] io_addr, io_wdata, io_rdata;
    logic        io_read, io_write, io_ready;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic        c_read, c_write, c_ready;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ready = 1'b0;
    logic        drop_err, timeout_err;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          len;
        int          gap;
    } acc_t;

    typedef struct {
        logic        side;
        logic [31:0] rdata;
    } rdy_t;

    acc_t acc_q[$];
    rdy_t rdy_q[$];
    acc_t cur;
    rdy_t r;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ack_delay = 2;
    int   scnt = 0;
    int   slen = 0;
    int   lowcnt = 0;
    logic strobe;
    logic prev_strobe = 1'b0;

    always #5 clk = ~clk;

    dmem_arbiter #(.TIMEOUT(8)) dut (
        .clk(clk), .rstn(rstn),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_read(io_read), .io_write(io_write),
        .io_rdata(io_rdata), .io_ready(io_ready),
        .c_addr(c_addr), .c_wdata(c_wdata), .c_read(c_read), .c_write(c_write),
        .c_rdata(c_rdata), .c_ready(c_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .drop_err(drop_err), .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, {31'b0, obs}, {31'b0, exp});
    endtask

    task automatic push_acc(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input int len, input int gap);
        acc_t e;
        e.wr = wr; e.addr = addr; e.wdata = wdata; e.len = len; e.gap = gap;
        acc_q.push_back(e);
    endtask

    task automatic push_rdy(input logic side, input logic [31:0] rdata);
        rdy_t e;
        e.side = side; e.rdata = rdata;
        rdy_q.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain(input int budget);
        int i = 0;
        while ((acc_q.size() != 0 || rdy_q.size() != 0) && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("drain", 32'(acc_q.size() + rdy_q.size()), 32'd0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chk1({tag, "_mem_read"}, mem_read, 1'b0);
        chk1({tag, "_mem_write"}, mem_write, 1'b0);
        chk({tag, "_io_rdata"}, io_rdata, 32'h0);
        chk({tag, "_c_rdata"}, c_rdata, 32'h0);
        chk1({tag, "_io_ready"}, io_ready, 1'b0);
        chk1({tag, "_c_ready"}, c_ready, 1'b0);
        chk1({tag, "_drop_err"}, drop_err, 1'b0);
        chk1({tag, "_timeout_err"}, timeout_err, 1'b0);
    endtask

    // Memory model: raise mem_ready for one cycle in the ack_delay-th strobe cycle.
    always @(negedge clk) begin
        if (mem_ready) begin
            mem_ready = 1'b0;
            scnt = 0;
        end else if (mem_read || mem_write) begin
            scnt++;
            if (ack_delay != 0 && scnt == ack_delay) begin
                mem_ready = 1'b1;
                mem_rdata = (mem_addr == 32'h2000) ? 32'hCAFE_BABE : (mem_addr ^ 32'h5A5A_0000);
            end
        end else begin
            scnt = 0;
        end
    end

    // Monitor: compare each memory access and each ready pulse against the scoreboards.
    always @(negedge clk) begin
        strobe = mem_read | mem_write;
        if (strobe && !prev_strobe) begin
            chk1("acc_expected", acc_q.size() != 0, 1'b1);
            if (acc_q.size() != 0) begin
                cur = acc_q.pop_front();
                chk1("acc_kind", mem_write, cur.wr);
                chk1("acc_excl", mem_read & mem_write, 1'b0);
                chk("acc_addr", mem_addr, cur.addr);
                chk("acc_wdata", mem_wdata, cur.wdata);
                if (cur.gap != 0) begin
                    chk("acc_gap", 32'(lowcnt), 32'(cur.gap));
                end
            end else begin
                cur.len = 0;
            end
            slen = 1;
        end else if (strobe) begin
            slen++;
            chk("acc_addr_hold", mem_addr, cur.addr);
        end else if (prev_strobe && cur.len != 0) begin
            chk("acc_len", 32'(slen), 32'(cur.len));
        end
        if (strobe) begin
            lowcnt = 0;
        end else begin
            lowcnt++;
        end
        prev_strobe = strobe;
        if (io_ready) begin
            chk1("io_ready_expected", rdy_q.size() != 0, 1'b1);
            if (rdy_q.size() != 0) begin
                r = rdy_q.pop_front();
                chk1("io_ready_side", SIDE_IO, r.side);
                chk("io_rdata", io_rdata, r.rdata);
            end
        end
        if (c_ready) begin
            chk1("c_ready_expected", rdy_q.size() != 0, 1'b1);
            if (rdy_q.size() != 0) begin
                r = rdy_q.pop_front();
                chk1("c_ready_side", SIDE_CORE, r.side);
                chk("c_rdata", c_rdata, r.rdata);
            end
        end
    end

    initial begin
        int lat;
        rstn = 1'b0;
        io_addr = 32'h0; io_wdata = 32'h0; io_read = 1'b0; io_write = 1'b0;
        c_addr = 32'h0; c_wdata = 32'h0; c_read = 1'b0; c_write = 1'b0;
        cyc(2);
        check_reset("rst0");
        rstn = 1'b1;
        cyc(1);

        // io single write, memory acks in the second strobe cycle
        ack_delay = 2;
        push_acc(1'b1, 32'h200, 32'h1234_5678, 2, 0);
        push_rdy(SIDE_IO, 32'h0);
        io_addr = 32'h200; io_wdata = 32'h1234_5678; io_write = 1'b1;
        cyc(1);
        io_write = 1'b0;
        wait_drain(20);
        chk1("wr_drop_err", drop_err, 1'b0);
        cyc(3);

        // core read held high; no second access while it stays high
        push_acc(1'b0, 32'h2000, 32'h0, 2, 0);
        push_rdy(SIDE_CORE, 32'hCAFE_BABE);
        c_addr = 32'h2000; c_read = 1'b1;
        wait_drain(20);
        cyc(8);
        chk("c_rdata_hold", c_rdata, 32'hCAFE_BABE);
        c_read = 1'b0;
        cyc(2);

        // minimum request-to-ready latency
        ack_delay = 1;
        io_wdata = 32'h0;
        push_acc(1'b0, 32'h100, 32'h0, 1, 0);
        push_rdy(SIDE_IO, 32'h5A5A_0100);
        io_addr = 32'h100; io_read = 1'b1;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (io_ready && lat == 0) lat = i;
        end
        chk("min_latency", 32'(lat), 32'd3);
        io_read = 1'b0;
        cyc(2);

        // reset while idle clears returned data
        rstn = 1'b0;
        cyc(1);
        check_reset("rst1");
        rstn = 1'b1;
        cyc(1);

        // tie after reset: io first, core second, one idle cycle between
        push_acc(1'b1, 32'h300, 32'hA0, 1, 0);
        push_acc(1'b1, 32'h3000, 32'hC0, 1, 1);
        push_rdy(SIDE_IO, 32'h0);
        push_rdy(SIDE_CORE, 32'h0);
        io_addr = 32'h300; io_wdata = 32'hA0; c_addr = 32'h3000; c_wdata = 32'hC0;
        io_write = 1'b1; c_write = 1'b1;
        cyc(1);
        io_write = 1'b0; c_write = 1'b0;
        wait_drain(20);
        cyc(2);

        // io alone makes io the last served side
        push_acc(1'b1, 32'h304, 32'hA4, 1, 0);
        push_rdy(SIDE_IO, 32'h0);
        io_addr = 32'h304; io_wdata = 32'hA4; io_write = 1'b1;
        cyc(1);
        io_write = 1'b0;
        wait_drain(20);
        cyc(2);

        // tie again: core first now
        io_wdata = 32'h0; c_wdata = 32'h0;
        push_acc(1'b0, 32'h3008, 32'h0, 1, 0);
        push_acc(1'b0, 32'h308, 32'h0, 1, 1);
        push_rdy(SIDE_CORE, 32'h5A5A_3008);
        push_rdy(SIDE_IO, 32'h5A5A_0308);
        io_addr = 32'h308; c_addr = 32'h3008;
        io_read = 1'b1; c_read = 1'b1;
        cyc(1);
        io_read = 1'b0; c_read = 1'b0;
        wait_drain(20);
        chk1("tie_drop_err", drop_err, 1'b0);
        cyc(2);

        // overflow: second io edge while the first is pending
        ack_delay = 4;
        push_acc(1'b1, 32'h400, 32'hB0, 4, 0);
        push_rdy(SIDE_IO, 32'h5A5A_0308);
        io_addr = 32'h400; io_wdata = 32'hB0; io_write = 1'b1;
        cyc(1);
        io_write = 1'b0;
        cyc(1);
        io_addr = 32'h404; io_wdata = 32'hB4; io_write = 1'b1;
        cyc(1);
        io_write = 1'b0;
        wait_drain(30);
        chk1("ovf_drop_err", drop_err, 1'b1);
        cyc(4);

        // normal io read, then a watchdog abort, then a normal write
        ack_delay = 2;
        io_wdata = 32'h0;
        push_acc(1'b0, 32'h800, 32'h0, 2, 0);
        push_rdy(SIDE_IO, 32'h5A5A_0800);
        io_addr = 32'h800; io_read = 1'b1;
        cyc(1);
        io_read = 1'b0;
        wait_drain(20);
        chk1("pre_timeout_err", timeout_err, 1'b0);
        cyc(2);
        ack_delay = 0;
        push_acc(1'b0, 32'h500, 32'h0, 8, 0);
        push_rdy(SIDE_IO, 32'h0);
        io_addr = 32'h500; io_read = 1'b1;
        cyc(1);
        io_read = 1'b0;
        wait_drain(30);
        chk1("timeout_err", timeout_err, 1'b1);
        cyc(2);
        ack_delay = 2;
        push_acc(1'b1, 32'h504, 32'hD4, 2, 0);
        push_rdy(SIDE_IO, 32'h0);
        io_addr = 32'h504; io_wdata = 32'hD4; io_write = 1'b1;
        cyc(1);
        io_write = 1'b0;
        wait_drain(20);
        chk1("timeout_sticky", timeout_err, 1'b1);
        cyc(2);

        // reset while an access is in flight
        ack_delay = 0;
        push_acc(1'b1, 32'h600, 32'hE0, 0, 0);
        c_addr = 32'h600; c_wdata = 32'hE0; c_write = 1'b1;
        cyc(1);
        c_write = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (mem_write) break;
            @(negedge clk);
        end
        chk1("busy_seen", mem_write, 1'b1);
        cyc(1);
        rstn = 1'b0;
        cyc(1);
        check_reset("rst2");
        rstn = 1'b1;
        cyc(10);
        chk("after_rst_queues", 32'(acc_q.size() + rdy_q.size()), 32'd0);

        // read and write together: treated as a write and flagged
        ack_delay = 1;
        push_acc(1'b1, 32'h700, 32'h77, 1, 0);
        push_rdy(SIDE_IO, 32'h0);
        io_addr = 32'h700; io_wdata = 32'h77; io_read = 1'b1; io_write = 1'b1;
        cyc(1);
        io_read = 1'b0; io_write = 1'b0;
        wait_drain(20);
        chk1("rw_drop_err", drop_err, 1'b1);
        cyc(4);
        chk("final_queues", 32'(acc_q.size() + rdy_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
